// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and compare helper for alu_multicycle.
// Optional divider build is selected with the ALU_DIV_EN macro.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD   = 4'd0;
  localparam logic [3:0] ALU_OP_SUB   = 4'd1;
  localparam logic [3:0] ALU_OP_AND   = 4'd2;
  localparam logic [3:0] ALU_OP_OR    = 4'd3;
  localparam logic [3:0] ALU_OP_XOR   = 4'd4;
  localparam logic [3:0] ALU_OP_SLL   = 4'd5;
  localparam logic [3:0] ALU_OP_SRL   = 4'd6;
  localparam logic [3:0] ALU_OP_SRA   = 4'd7;
  localparam logic [3:0] ALU_OP_SLT   = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU  = 4'd9;
  localparam logic [3:0] ALU_OP_MUL   = 4'd10;
  localparam logic [3:0] ALU_OP_MULHU = 4'd11;
  localparam logic [3:0] ALU_OP_DIVU  = 4'd12;
  localparam logic [3:0] ALU_OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Width-independent less-than: borrow of a-b decides unless signs differ.
  function automatic logic less_than(input logic a_msb, input logic b_msb,
                                     input logic borrow, input logic is_signed);
    if (is_signed && (a_msb != b_msb)) begin
      return a_msb;
    end else begin
      return borrow;
    end
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between execute control and alu_multicycle.
interface alu_multicycle_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] op_0;
  logic [WIDTH-1:0] op_1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ZERO;
  logic             NEGATIVE;
  logic             CARRY;
  logic             OVERFLOW;

  modport master (
    output in_valid, opcode, op_0, op_1, out_ready,
    input  in_ready, out_valid, out, ZERO, NEGATIVE, CARRY, OVERFLOW
  );

  modport slave (
    input  in_valid, opcode, op_0, op_1, out_ready,
    output in_ready, out_valid, out, ZERO, NEGATIVE, CARRY, OVERFLOW
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Iterative radix-2 shift-add multiplier; restoring unsigned divider when ALU_DIV_EN is defined.
// The first step runs on the start edge, so done rises WIDTH-1 cycles after start.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] step_in_s;
  logic [2*WIDTH-1:0] next_acc_s;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   step_opnd_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               active_r;

  // acc holds {partial product, remaining multiplier bits}; add then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

`ifdef ALU_DIV_EN
  logic div_r;
  logic div_sel_s;

  // acc holds {remainder, dividend/quotient}; a zero divisor yields all-ones and the dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (shifted >= {1'b0, dvsr}) begin
      return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Operation kind is captured on start and held for the rest of the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_r <= 1'b0;
    end else if (start) begin
      div_r <= div;
    end else begin
      div_r <= div_r;
    end
  end

  assign div_sel_s = start ? div : div_r;
`else
  logic unused_div_s;
  assign unused_div_s = div;
`endif

  // Select the step inputs: fresh operands on start, running state otherwise.
  always_comb begin
    step_in_s   = acc_r;
    step_opnd_s = opnd_r;
    if (start) begin
      step_in_s   = {{WIDTH{1'b0}}, a};
      step_opnd_s = b;
    end else begin
      step_in_s   = acc_r;
      step_opnd_s = opnd_r;
    end
`ifdef ALU_DIV_EN
    if (div_sel_s) begin
      next_acc_s = div_step(step_in_s, step_opnd_s);
    end else begin
      next_acc_s = mul_step(step_in_s, step_opnd_s);
    end
`else
    next_acc_s = mul_step(step_in_s, step_opnd_s);
`endif
  end

  // Iteration state: WIDTH steps in total, counter walks WIDTH-1 down to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
    end else if (start) begin
      acc_r    <= next_acc_s;
      opnd_r   <= b;
      cnt_r    <= CNT_W'(WIDTH - 1);
      active_r <= 1'b1;
    end else if (active_r && (cnt_r != {CNT_W{1'b0}})) begin
      acc_r    <= next_acc_s;
      cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      active_r <= 1'b0;
    end
  end

  assign done = active_r & (cnt_r == {CNT_W{1'b0}});
  assign hi   = acc_r[2*WIDTH-1:WIDTH];
  assign lo   = acc_r[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes; result and flags are registered together.
// Define ALU_DIV_EN to enable DIVU/REMU; otherwise opcodes 12/13 are reserved.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic               clock,
  input logic               reset,
  alu_multicycle_if.slave   bus
);

  alu_state_e       state_r, next_state_s;
  logic [3:0]       op_r;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r, neg_r, carry_r, ovf_r;

  logic             accept_s, iter_op_s, div_op_s, start_s, load_s;
  logic [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0] alu_res_s, iter_res_s, iter_hi_s, iter_lo_s, res_s;
  logic             alu_carry_s, alu_ovf_s, carry_s, ovf_s, iter_done_s;

  assign a_s      = bus.op_0;
  assign b_s      = bus.op_1;
  assign accept_s = bus.in_valid & in_ready_r;
  assign div_op_s = (bus.opcode == ALU_OP_DIVU) | (bus.opcode == ALU_OP_REMU);
`ifdef ALU_DIV_EN
  assign iter_op_s = (bus.opcode == ALU_OP_MUL) | (bus.opcode == ALU_OP_MULHU) | div_op_s;
`else
  assign iter_op_s = (bus.opcode == ALU_OP_MUL) | (bus.opcode == ALU_OP_MULHU);
`endif
  assign iter_res_s = ((op_r == ALU_OP_MULHU) || (op_r == ALU_OP_REMU)) ? iter_hi_s : iter_lo_s;

  // Single-cycle datapath evaluated on the operands presented at accept.
  always_comb begin
    sum_s       = {1'b0, a_s} + {1'b0, b_s};
    diff_s      = {1'b0, a_s} - {1'b0, b_s};
    shamt_s     = b_s[SHAMT_W-1:0];
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (bus.opcode)
      ALU_OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALU_OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = ~diff_s[WIDTH];
        alu_ovf_s   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      ALU_OP_AND:  alu_res_s = a_s & b_s;
      ALU_OP_OR:   alu_res_s = a_s | b_s;
      ALU_OP_XOR:  alu_res_s = a_s ^ b_s;
      ALU_OP_SLL:  alu_res_s = a_s << shamt_s;
      ALU_OP_SRL:  alu_res_s = a_s >> shamt_s;
      ALU_OP_SRA:  alu_res_s = $signed(a_s) >>> shamt_s;
      ALU_OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}},
                                less_than(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH], 1'b1)};
      ALU_OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}},
                                less_than(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH], 1'b0)};
      default:     alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and load control; DONE never accepts, even with out_ready high.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    load_s       = 1'b0;
    res_s        = alu_res_s;
    carry_s      = alu_carry_s;
    ovf_s        = alu_ovf_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (iter_op_s) begin
            next_state_s = ST_BUSY;
            start_s      = 1'b1;
          end else begin
            next_state_s = ST_DONE;
            load_s       = 1'b1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done_s) begin
          next_state_s = ST_DONE;
          load_s       = 1'b1;
          res_s        = iter_res_s;
          carry_s      = 1'b0;
          ovf_s        = 1'b0;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with handshake outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_IDLE);
      out_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Result, flags and latched opcode; flags always describe the loaded result.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r    <= 4'd0;
      out_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
      neg_r   <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r <= bus.opcode;
      end else begin
        op_r <= op_r;
      end
      if (load_s) begin
        out_r   <= res_s;
        zero_r  <= (res_s == {WIDTH{1'b0}});
        neg_r   <= res_s[WIDTH-1];
        carry_r <= carry_s;
        ovf_r   <= ovf_s;
      end else begin
        out_r   <= out_r;
      end
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clock (clock),
    .reset (reset),
    .start (start_s),
    .div   (div_op_s),
    .a     (a_s),
    .b     (b_s),
    .done  (iter_done_s),
    .hi    (iter_hi_s),
    .lo    (iter_lo_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.ZERO      = zero_r;
  assign bus.NEGATIVE  = neg_r;
  assign bus.CARRY     = carry_r;
  assign bus.OVERFLOW  = ovf_r;

endmodule
